// File: rtl/tick_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler_pkg
// Description : Shared FSM encodings and default divider constants for the
//               tick scheduler and its strobe divider.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_scheduler_pkg;

    // Game sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    // Default divider constants for a 100 MHz master clock
    localparam int unsigned C_PIX_DIV    = 4;          // 25 MHz pixel enable
    localparam int unsigned C_SEG_DIV    = 262144;     // ~381 Hz digit mux
    localparam int unsigned C_BLINK_HALF = 33554432;   // ~1.49 Hz blink
    localparam int unsigned C_GAME_DIV   = 2097152;    // ~47.7 Hz game tick
    localparam int          C_CNT_W      = 26;

endpackage
`default_nettype wire

// File: rtl/tick_scheduler_strobe_div.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler_strobe_div
// Description : Counter 0..DIV-1 with a registered one-cycle strobe in the
//               cycle after the terminal count. A synchronous hold keeps the
//               counter at zero and the strobe low.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler_strobe_div
    import tick_scheduler_pkg::*;
#(
    parameter int unsigned DIV = C_PIX_DIV,
    parameter int          W   = C_CNT_W
) (
    input  logic clk,
    input  logic clr,
    input  logic hold,
    output logic strobe
);

    localparam logic [W-1:0] c_last = W'(DIV - 1);

    logic [W-1:0] r_cnt;
    logic         r_strobe;

    // Count and raise the strobe one cycle after the terminal value
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (hold) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (r_cnt == c_last) begin
            r_cnt    <= '0;
            r_strobe <= 1'b1;
        end else begin
            r_cnt    <= r_cnt + W'(1);
            r_strobe <= 1'b0;
        end
    end

    assign strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Central clock-enable scheduler. Free-running pixel, segment
//               and blink dividers plus a game-tick generator sequenced by a
//               run/pause/single-step FSM with a latched speed select.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int unsigned PIX_DIV    = C_PIX_DIV,
    parameter int unsigned SEG_DIV    = C_SEG_DIV,
    parameter int unsigned BLINK_HALF = C_BLINK_HALF,
    parameter int unsigned GAME_DIV   = C_GAME_DIV,
    parameter int          CNT_W      = C_CNT_W
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        step,
    input  logic [1:0]  speed,
    output logic        pix_en,
    output logic        seg_en,
    output logic        blink,
    output logic        game_tick,
    output logic        running,
    output logic [15:0] tick_count
);

    localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] c_game_base  = CNT_W'(GAME_DIV);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_blink_cnt;
    logic [CNT_W-1:0]   r_game_cnt;
    logic [CNT_W-1:0]   w_game_last;
    logic [1:0]         r_speed_q;
    logic               r_blink;
    logic               r_game_tick;
    logic               r_running;
    logic [15:0]        r_tick_count;
    logic               w_boundary;
    logic               w_tick_nxt;
    logic               w_start_go;

    // Pixel and segment enables never stop, so their hold is tied low
    tick_scheduler_strobe_div #(.DIV(PIX_DIV), .W(CNT_W)) u_pix_div (
        .clk    (clk),
        .clr    (clr),
        .hold   (1'b0),
        .strobe (pix_en)
    );

    tick_scheduler_strobe_div #(.DIV(SEG_DIV), .W(CNT_W)) u_seg_div (
        .clk    (clk),
        .clr    (clr),
        .hold   (1'b0),
        .strobe (seg_en)
    );

    // Blink half-period counter toggling the blink level at each wrap
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + CNT_W'(1);
        end
    end

    // Game period shrinks by powers of two with the latched speed
    assign w_game_last = (c_game_base >> r_speed_q) - CNT_W'(1);
    assign w_boundary  = (r_state != ST_IDLE) && (r_game_cnt == w_game_last);
    assign w_start_go  = (r_state == ST_IDLE) && start && !stop;

    // Next-state and tick request; stop overrides every other input
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = 1'b0;
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    w_tick_nxt = w_boundary;
                    if (pause) w_state_nxt = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (pause)     w_state_nxt = ST_RUN;
                    else if (step) w_state_nxt = ST_STEP;
                end
                ST_STEP: begin
                    if (w_boundary) begin
                        w_tick_nxt  = 1'b1;
                        w_state_nxt = ST_PAUSED;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Game counter, held at zero while idle; speed only changes at a wrap
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_game_cnt <= '0;
            r_speed_q  <= 2'd0;
        end else begin
            if ((r_state == ST_IDLE) || stop || w_boundary) r_game_cnt <= '0;
            else                                            r_game_cnt <= r_game_cnt + CNT_W'(1);
            if (w_start_go || w_boundary) r_speed_q <= speed;
        end
    end

    // Registered game outputs and tick counter
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_game_tick  <= 1'b0;
            r_running    <= 1'b0;
            r_tick_count <= 16'd0;
        end else begin
            r_game_tick <= w_tick_nxt;
            r_running   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP);
            if (w_start_go)      r_tick_count <= 16'd0;
            else if (w_tick_nxt) r_tick_count <= r_tick_count + 16'd1;
        end
    end

    assign blink      = r_blink;
    assign game_tick  = r_game_tick;
    assign running    = r_running;
    assign tick_count = r_tick_count;

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Self-checking bench for tick_scheduler with small dividers.
//               A timeline model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int PIX = 4;
    localparam int SEG = 8;
    localparam int BH  = 16;
    localparam int GD  = 32;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_STEP   = 3;

    logic        clk   = 1'b0;
    logic        clr   = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        pause = 1'b0;
    logic        step  = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        pix_en;
    logic        seg_en;
    logic        blink;
    logic        game_tick;
    logic        running;
    logic [15:0] tick_count;

    int checks = 0;
    int errors = 0;

    // Reference model: edge count since reset release, mode, absolute time
    // of the next game boundary, expected tick/running/count.
    int          n     = 0;
    int          m_st  = M_IDLE;
    int          m_bnd = 0;
    logic        m_tick = 1'b0;
    logic        m_run  = 1'b0;
    logic [15:0] m_cnt  = 16'd0;

    tick_scheduler #(
        .PIX_DIV    (PIX),
        .SEG_DIV    (SEG),
        .BLINK_HALF (BH),
        .GAME_DIV   (GD),
        .CNT_W      (26)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .step       (step),
        .speed      (speed),
        .pix_en     (pix_en),
        .seg_en     (seg_en),
        .blink      (blink),
        .game_tick  (game_tick),
        .running    (running),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, want, n);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        m_st   = M_IDLE;
        m_bnd  = 0;
        m_tick = 1'b0;
        m_run  = 1'b0;
        m_cnt  = 16'd0;
    endtask

    task automatic model_edge();
        bit bnd;
        n++;
        bnd    = (m_st != M_IDLE) && (n == m_bnd);
        m_tick = bnd && !stop && (m_st == M_RUN || m_st == M_STEP);
        if (m_tick) m_cnt = m_cnt + 16'd1;
        if (bnd) m_bnd = n + (GD >> speed);
        if (stop) begin
            m_st = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: if (start) begin
                    m_st  = M_RUN;
                    m_cnt = 16'd0;
                    m_bnd = n + (GD >> speed);
                end
                M_RUN:    if (pause) m_st = M_PAUSED;
                M_PAUSED: if (pause) m_st = M_RUN; else if (step) m_st = M_STEP;
                default:  if (bnd) m_st = M_PAUSED;
            endcase
        end
        m_run = (m_st == M_RUN) || (m_st == M_STEP);
    endtask

    task automatic check_all();
        chk("pix_en",     16'(pix_en),    16'(n > 0 && n % PIX == 0));
        chk("seg_en",     16'(seg_en),    16'(n > 0 && n % SEG == 0));
        chk("blink",      16'(blink),     16'((n / BH) % 2));
        chk("game_tick",  16'(game_tick), 16'(m_tick));
        chk("running",    16'(running),   16'(m_run));
        chk("tick_count", tick_count,     m_cnt);
    endtask

    // One clock: inputs sampled at the edge, pulses cleared, outputs checked
    task automatic cycle();
        @(posedge clk);
        if (clr) model_reset(); else model_edge();
        #1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        step  = 1'b0;
        check_all();
    endtask

    initial begin
        int first;
        int ticks;
        int t[3];
        logic [15:0] saved;

        // Reset held, then released just after an edge: next edge is edge 1
        repeat (3) cycle();
        clr = 1'b0;
        repeat (10) cycle();

        // Start sampled at edge 11: first tick at 43, then every 32
        start = 1'b1;
        cycle();
        first = -1;
        for (int i = 0; i < 100 && first < 0; i++) begin
            cycle();
            if (game_tick === 1'b1) first = n;
        end
        chk("first_tick_cycle", 16'(first), 16'd43);
        ticks = 1;
        for (int i = 0; i < 200 && ticks < 3; i++) begin
            cycle();
            if (game_tick === 1'b1) ticks++;
        end
        chk("third_tick_cycle", 16'(n), 16'd107);
        chk("count_after_3", tick_count, 16'd3);

        // Speed 2 mid-period: current 32-cycle period completes, then 8
        repeat (5) cycle();
        speed = 2'd2;
        ticks = 0;
        for (int i = 0; i < 200 && ticks < 3; i++) begin
            cycle();
            if (game_tick === 1'b1) begin
                t[ticks] = n;
                ticks++;
            end
        end
        chk("speed_tick0", 16'(t[0]), 16'd139);
        chk("speed_tick1", 16'(t[1]), 16'd147);
        chk("speed_tick2", 16'(t[2]), 16'd155);

        // Pause: frozen for 200 cycles
        pause = 1'b1;
        cycle();
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (game_tick === 1'b1) ticks++;
        end
        chk("ticks_paused", 16'(ticks), 16'd0);
        chk("running_paused", 16'(running), 16'd0);

        // Single step, with a second step while stepping ignored
        step = 1'b1;
        cycle();
        step = 1'b1;
        cycle();
        ticks = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (game_tick === 1'b1) ticks++;
        end
        chk("step_ticks", 16'(ticks), 16'd1);
        chk("running_after_step", 16'(running), 16'd0);

        // Resume, then pause+step together: paused, no extra ticks
        pause = 1'b1;
        cycle();
        repeat (3) cycle();
        pause = 1'b1;
        step  = 1'b1;
        cycle();
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (game_tick === 1'b1) ticks++;
        end
        chk("pause_step_ticks", 16'(ticks), 16'd0);

        // Resume, then stop+start together: idle, count preserved
        pause = 1'b1;
        cycle();
        repeat (10) cycle();
        saved = m_cnt;
        stop  = 1'b1;
        start = 1'b1;
        cycle();
        repeat (5) cycle();
        chk("stop_start_count", tick_count, saved);
        chk("stop_start_running", 16'(running), 16'd0);

        // Stop exactly on a boundary: tick suppressed
        start = 1'b1;
        cycle();
        for (int i = 0; i < 100 && n != m_bnd - 1; i++) cycle();
        saved = m_cnt;
        stop  = 1'b1;
        cycle();
        chk("stop_bnd_tick", 16'(game_tick), 16'd0);
        chk("stop_bnd_count", tick_count, saved);

        // Random pulses and speed changes, including coincident events
        for (int i = 0; i < 600; i++) begin
            stop  = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 99) < 6);
            pause = ($urandom_range(0, 99) < 5);
            step  = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 15) == 0) speed = 2'($urandom);
            cycle();
        end

        // Async clear mid-run with tick_count = 5
        stop = 1'b1;
        cycle();
        speed = 2'd3;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 200 && m_cnt != 16'd5; i++) cycle();
        chk("pre_clr_count", tick_count, 16'd5);
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        chk("async_pix", 16'(pix_en), 16'd0);
        chk("async_seg", 16'(seg_en), 16'd0);
        chk("async_blink", 16'(blink), 16'd0);
        chk("async_tick", 16'(game_tick), 16'd0);
        chk("async_running", 16'(running), 16'd0);
        chk("async_count", tick_count, 16'd0);
        repeat (2) cycle();
        clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("pix_resume", 16'(pix_en), 16'(i == 4));
        end
        repeat (40) cycle();
        chk("idle_after_clr_count", tick_count, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Central clock-enable scheduler for the Flappy Bird top level. Runs entirely in the 100 MHz clk domain.
- Produces single-cycle enable strobes for the VGA pixel pipeline, the 7-segment mux and the game-logic update, plus a blink level. Downstream logic uses these as enables, not as derived clocks.
- Adds run/pause/single-step sequencing and a speed select for the game tick, so gameplay can be started, frozen, stepped and sped up without touching the video timing.

Parameters:
- PIX_DIV, 4: clk cycles per pix_en strobe (25 MHz).
- SEG_DIV, 262144: clk cycles per seg_en strobe (~381 Hz).
- BLINK_HALF, 33554432: clk cycles per blink level toggle (~1.49 Hz square wave).
- GAME_DIV, 2097152: base clk cycles per game tick at speed 0 (~47.7 Hz).
- CNT_W, 26: width of internal counters; must hold max(SEG_DIV, BLINK_HALF, GAME_DIV) - 1.

Ports:
- clk  in  1  100 MHz master clock.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; IDLE -> RUN.
- stop  in  1  pulse; any state -> IDLE.
- pause  in  1  pulse; toggles RUN <-> PAUSED.
- step  in  1  pulse; in PAUSED, request exactly one game tick.
- speed  in  2  game period = GAME_DIV >> speed; 0 = slowest, 3 = 8x.
- pix_en  out  1  1-cycle strobe every PIX_DIV cycles.
- seg_en  out  1  1-cycle strobe every SEG_DIV cycles.
- blink  out  1  level, toggles every BLINK_HALF cycles.
- game_tick  out  1  1-cycle game update strobe.
- running  out  1  high in RUN or STEP.
- tick_count  out  16  number of game_tick strobes since start; wraps.

Behaviour:
- Reset (clr high):
  - All counters = 0; state = IDLE.
  - pix_en = 0, seg_en = 0, blink = 0, game_tick = 0, running = 0, tick_count = 0.
- Free-running dividers (pix, seg, blink):
  - Run in every FSM state; only clr resets them.
  - Each counter counts 0..DIV-1 and then wraps to 0.
  - The strobe is registered: it is high in the cycle after the counter reaches DIV-1.
  - First pix_en after clr deassert occurs at cycle PIX_DIV (cycles counted from 1); likewise for seg_en.
  - blink toggles in the cycle after its counter reaches BLINK_HALF-1.
- Game counter:
  - Counts 0..P-1, where P = GAME_DIV >> speed_q.
  - Held at 0 in IDLE; runs in RUN, PAUSED and STEP.
  - A wrap (counter == P-1) is a "boundary".
  - speed_q is latched from speed only at a boundary or on start, so the period never changes mid-count.
- FSM states: IDLE, RUN, PAUSED, STEP.
  - IDLE: on start, clear the game counter and tick_count, latch speed_q, go to RUN.
  - RUN: at each boundary, assert game_tick for 1 cycle (registered, cycle after the boundary). On pause, go to PAUSED.
  - PAUSED: game_tick = 0. On pause, go to RUN. On step, go to STEP.
  - STEP: at the next boundary, emit one game_tick, then return to PAUSED. pause and step are ignored while in STEP.
- tick_count increments with every game_tick and wraps 0xFFFF -> 0.
- Priority when inputs arrive in the same cycle:
  - stop > start > pause > step.
  - stop in any state goes to IDLE next cycle, and any pending game_tick is suppressed.
  - start outside IDLE is ignored.
  - pause and step together in RUN: pause is taken, step is dropped.
  - A boundary in the same cycle as pause in RUN: the tick is still emitted, then PAUSED.
- running = (state == RUN) || (state == STEP), registered.
- clr mid-operation: immediate return to the full reset values above, regardless of state.
- Inputs are already synchronized, single-cycle pulses. Debounce is done elsewhere.

Decomposition:
- Shared package holds:
  - FSM state encodings: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSED = 2'd2, ST_STEP = 2'd3.
  - Default divider constants.
- One sub-module, strobe_div (parameter DIV, W). It is a counter plus registered wrap strobe with a synchronous hold/clear.
  - Instantiated for pix and seg.
  - Blink and game use the same counter pattern inline, because game needs a variable terminal value and blink needs a toggle output.

Test Plan:
Bench overrides: PIX_DIV = 4, SEG_DIV = 8, BLINK_HALF = 16, GAME_DIV = 32.
- Reset/dividers: release clr at cycle 0, no start.
  - pix_en high at cycles 4, 8, 12.
  - seg_en high at cycles 8, 16.
  - blink rises at 16 and falls at 32.
  - game_tick stays 0.
- Run at speed 0: start at cycle 10 -> game_tick every 32 cycles, first at cycle 43; tick_count = 3 after the third tick.
- Speed change: speed = 2 mid-period -> current 32-cycle period completes, next periods are 8 cycles.
- Pause/step:
  - pause -> no ticks for 200 cycles, running = 0.
  - step -> exactly one game_tick at the next boundary, then state returns to PAUSED.
  - A second step issued during STEP is ignored.
- Simultaneous events:
  - pause + step in RUN -> PAUSED, no extra tick.
  - stop + start -> IDLE, tick_count unchanged.
  - stop on a boundary cycle -> no game_tick.
- Async reset mid-RUN: clr pulse with tick_count = 5 -> all outputs 0 that cycle, state IDLE; pix_en resumes 4 cycles after clr falls.
